// File: rtl/seq_alu.sv
// seq_alu: registered ALU with flag file, iterative shifter/rotator and shift-add multiplier; SEQ_ALU_OVERFLOW_FLAG_EN adds fl_v.
// Latency: done at +1 for single-cycle ops, +k+1 for shift/rotate by k>0, +WIDTH+1 for MUL.
// Backpressure: busy is high while iterating and start is ignored then; a new start is taken in the done cycle.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             fl_carry,
    output logic             fl_lt,
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
    output logic             fl_z,
    output logic             fl_v
`else
    output logic             fl_z
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_ASR  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;

    logic [SHW-1:0]   sh_amt;
    logic             is_shift;
    logic             is_nop;

    assign sh_amt   = b[SHW-1:0];
    assign is_shift = (op >= OP_SHL) && (op <= OP_ASR);
    assign is_nop   = (op == 4'hE) || (op == 4'hF);

    // Single-cycle datapath, evaluated on the accept cycle
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] imm_res;
    logic             imm_c;

    always_comb begin
        b_eff = ((op == OP_SUB) || (op == OP_SBC)) ? ~b : b;
        case (op)
            OP_ADC, OP_SBC: cin = fl_carry;
            OP_SUB:         cin = 1'b1;
            default:        cin = 1'b0;
        endcase
        sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        imm_res = a;
        imm_c   = fl_carry;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                imm_res = sum[WIDTH-1:0];
                imm_c   = sum[WIDTH];
            end
            OP_NAND: begin imm_res = ~(a & b); imm_c = 1'b0; end
            OP_AND:  begin imm_res = a & b;    imm_c = 1'b0; end
            OP_OR:   begin imm_res = a | b;    imm_c = 1'b0; end
            OP_XOR:  begin imm_res = a ^ b;    imm_c = 1'b0; end
            // zero-amount shifts pass a through with carry held
            default: ;
        endcase
    end

    // One shift/rotate step on the working register
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;

    always_comb begin
        sh_next = acc_lo;
        sh_out  = 1'b0;
        case (op_q)
            OP_SHL: begin sh_next = {acc_lo[WIDTH-2:0], 1'b0};             sh_out = acc_lo[WIDTH-1]; end
            OP_SHR: begin sh_next = {1'b0, acc_lo[WIDTH-1:1]};             sh_out = acc_lo[0];       end
            OP_ROL: begin sh_next = {acc_lo[WIDTH-2:0], acc_lo[WIDTH-1]};  sh_out = acc_lo[WIDTH-1]; end
            OP_ROR: begin sh_next = {acc_lo[0], acc_lo[WIDTH-1:1]};        sh_out = acc_lo[0];       end
            OP_ASR: begin sh_next = {acc_lo[WIDTH-1], acc_lo[WIDTH-1:1]};  sh_out = acc_lo[0];       end
            default: ;
        endcase
    end

    // Shift-add step: {acc_hi, acc_lo} holds partial product and remaining multiplier bits
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;

    assign mul_sum  = {1'b0, acc_hi} + {1'b0, opa_q & {WIDTH{acc_lo[0]}}};
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
    logic imm_v;
    logic sh_msb_chg;
    logic v_acc;

    assign imm_v      = (op <= OP_SBC) && (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sh_msb_chg = sh_next[WIDTH-1] != acc_lo[WIDTH-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            opa_q    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fl_carry <= 1'b0;
            fl_lt    <= 1'b0;
            fl_z     <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
            fl_v     <= 1'b0;
            v_acc    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        opa_q <= a;
                        if (is_shift && (sh_amt != '0)) begin
                            state  <= SHIFT;
                            busy   <= 1'b1;
                            acc_lo <= a;
                            cnt    <= CW'(sh_amt);
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
                            v_acc  <= 1'b0;
`endif
                        end else if (op == OP_MUL) begin
                            state  <= MUL;
                            busy   <= 1'b1;
                            acc_hi <= '0;
                            acc_lo <= b;
                            cnt    <= CW'(WIDTH);
                        end else begin
                            done <= 1'b1;
                            if (!is_nop) begin
                                result   <= imm_res;
                                fl_carry <= imm_c;
                                fl_lt    <= imm_res[WIDTH-1];
                                fl_z     <= (imm_res == '0);
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
                                fl_v     <= imm_v;
`endif
                            end
                        end
                    end
                end
                SHIFT: begin
                    acc_lo <= sh_next;
                    cnt    <= cnt - CW'(1);
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
                    v_acc  <= v_acc | sh_msb_chg;
`endif
                    if (cnt == CW'(1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= sh_next;
                        fl_carry <= sh_out;
                        fl_lt    <= sh_next[WIDTH-1];
                        fl_z     <= (sh_next == '0);
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
                        fl_v     <= ((op_q == OP_SHL) || (op_q == OP_ASR)) && (v_acc || sh_msb_chg);
`endif
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= mul_lo_n;
                        fl_carry <= |mul_hi_n;
                        fl_lt    <= mul_lo_n[WIDTH-1];
                        fl_z     <= (mul_lo_n == '0);
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
                        fl_v     <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed bench for seq_alu against a plain-arithmetic reference model.
module tb_seq_alu;

    localparam int W   = 8;
    localparam int SHW = $clog2(W);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBC = 4'h3;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         fl_carry;
    logic         fl_lt;
    logic         fl_z;
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
    logic         fl_v;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference flag file
    longint m_res = 0;
    bit     m_c   = 1'b0;
    bit     m_z   = 1'b0;
    bit     m_lt  = 1'b0;
    bit     m_v   = 1'b0;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .fl_carry (fl_carry),
        .fl_lt    (fl_lt),
        .fl_z     (fl_z)
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
        , .fl_v   (fl_v)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Computes the architectural effect of one op and its completion latency.
    task automatic model_op(input logic [3:0] o, input longint ua, input longint ub, output int lat);
        longint mask, r, bb, cin, s, sa, p, top;
        bit     c, v;
        int     k;
        mask = (longint'(1) << W) - 1;
        k    = int'(ub % (longint'(1) << SHW));
        r    = m_res;
        c    = m_c;
        v    = 1'b0;
        lat  = 1;
        sa   = ((ua >> (W-1)) & 1) != 0 ? ua - (longint'(1) << W) : ua;
        case (o)
            4'h0, 4'h1, 4'h2, 4'h3: begin
                bb  = (o >= 4'h2) ? (mask - ub) : ub;
                cin = (o == 4'h0) ? 0 : (o == 4'h2) ? 1 : longint'(m_c);
                s   = ua + bb + cin;
                r   = s & mask;
                c   = (s >> W) != 0;
                v   = (((ua >> (W-1)) & 1) == ((bb >> (W-1)) & 1)) && (((r >> (W-1)) & 1) != ((ua >> (W-1)) & 1));
            end
            4'h4: begin r = mask - (ua & ub); c = 1'b0; end
            4'h5: begin r = ua & ub;          c = 1'b0; end
            4'h6: begin r = ua | ub;          c = 1'b0; end
            4'h7: begin r = ua ^ ub;          c = 1'b0; end
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC: begin
                if (k == 0) begin
                    r = ua;
                end else begin
                    lat = k + 1;
                    case (o)
                        4'h8: begin
                            r   = (ua << k) & mask;
                            c   = ((ua >> (W-k)) & 1) != 0;
                            top = ua >> (W-1-k);
                            v   = (top != 0) && (top != ((longint'(1) << (k+1)) - 1));
                        end
                        4'h9: begin r = ua >> k; c = ((ua >> (k-1)) & 1) != 0; end
                        4'hA: begin r = ((ua << k) | (ua >> (W-k))) & mask; c = (r & 1) != 0; end
                        4'hB: begin r = ((ua >> k) | (ua << (W-k))) & mask; c = ((r >> (W-1)) & 1) != 0; end
                        default: begin r = (sa >>> k) & mask; c = ((sa >>> (k-1)) & 1) != 0; end
                    endcase
                end
            end
            4'hD: begin
                p   = ua * ub;
                r   = p & mask;
                c   = (p >> W) != 0;
                lat = W + 1;
            end
            default: ;
        endcase
        if (o < 4'hE) begin
            m_res = r;
            m_c   = c;
            m_z   = (r == 0);
            m_lt  = ((r >> (W-1)) & 1) != 0;
            m_v   = v;
        end
    endtask

    // Issues one op at the current cycle, optionally re-strobes start while busy, and checks the completion.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv, input bit poke);
        int exp_lat, lat, bcnt;
        model_op(o, longint'(av), longint'(bv), exp_lat);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke && exp_lat > 1) begin
            start = 1'b1; op = OP_ADD; a = W'($urandom); b = W'($urandom);
        end
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 80) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        check($sformatf("op%0h latency", o), lat, exp_lat);
        check($sformatf("op%0h busy_cycles", o), bcnt, exp_lat - 1);
        check($sformatf("op%0h busy_at_done", o), busy, 1'b0);
        check($sformatf("op%0h result", o), result, m_res);
        check($sformatf("op%0h fl_carry", o), fl_carry, m_c);
        check($sformatf("op%0h fl_lt", o), fl_lt, m_lt);
        check($sformatf("op%0h fl_z", o), fl_z, m_z);
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
        check($sformatf("op%0h fl_v", o), fl_v, m_v);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        repeat (3) @(posedge clk);
        #1;
        check("rst result", result, '0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst fl_carry", fl_carry, 1'b0);
        check("rst fl_lt", fl_lt, 1'b0);
        check("rst fl_z", fl_z, 1'b0);
`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
        check("rst fl_v", fl_v, 1'b0);
`endif
        rst = 1'b0;

        run_op(OP_ADD, 8'hFF, 8'h01, 1'b0);
        check("tp add res", result, 8'h00);
        check("tp add c", fl_carry, 1'b1);
        check("tp add z", fl_z, 1'b1);

        run_op(OP_SUB, 8'h05, 8'h07, 1'b0);
        check("tp sub res", result, 8'hFE);
        check("tp sub c", fl_carry, 1'b0);
        check("tp sub lt", fl_lt, 1'b1);

        run_op(OP_SBC, 8'h10, 8'h01, 1'b0);
        check("tp sbc res", result, 8'h0E);
        check("tp sbc c", fl_carry, 1'b1);

        run_op(OP_ROR, 8'h81, 8'h03, 1'b0);
        check("tp ror res", result, 8'h30);
        check("tp ror c", fl_carry, 1'b0);

        run_op(OP_SHL, 8'h80, 8'h01, 1'b0);
        check("tp shl c", fl_carry, 1'b1);
        run_op(OP_ROR, 8'h81, 8'h00, 1'b0);
        check("tp ror0 res", result, 8'h81);
        check("tp ror0 c held", fl_carry, 1'b1);

        run_op(OP_MUL, 8'h0D, 8'h0B, 1'b1);
        check("tp mul res", result, 8'h8F);
        check("tp mul c", fl_carry, 1'b0);
        check("tp mul lt", fl_lt, 1'b1);

        run_op(OP_MUL, 8'h10, 8'h20, 1'b0);
        check("tp mul2 res", result, 8'h00);
        check("tp mul2 c", fl_carry, 1'b1);
        check("tp mul2 z", fl_z, 1'b1);

        // Reset in the middle of a multiply
        start = 1'b1; op = OP_MUL; a = 8'h33; b = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst mid busy before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst mid busy", busy, 1'b0);
        check("rst mid result", result, '0);
        check("rst mid done", done, 1'b0);
        check("rst mid flags", {fl_carry, fl_lt, fl_z}, 3'b000);
        rst = 1'b0;
        m_res = 0; m_c = 1'b0; m_z = 1'b0; m_lt = 1'b0; m_v = 1'b0;
        dcnt = 0;
        repeat (W + 3) begin
            if (done === 1'b1) dcnt++;
            @(posedge clk); #1;
        end
        check("rst mid no done", dcnt, 0);

`ifdef SEQ_ALU_OVERFLOW_FLAG_EN
        run_op(OP_ADD, 8'h7F, 8'h01, 1'b0);
        check("tp ovf res", result, 8'h80);
        check("tp ovf v", fl_v, 1'b1);
        run_op(OP_ADD, 8'h01, 8'h01, 1'b0);
        check("tp novf v", fl_v, 1'b0);
`endif

        for (int i = 0; i < 300; i++) begin
            run_op(4'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
